// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared widths, word/block types and serializer state encoding
package aes_pkg;

    localparam int WORD_W  = 32;
    localparam int NWORDS  = 4;
    localparam int BLOCK_W = WORD_W * NWORDS;
    localparam int SEL_W   = $clog2(NWORDS);

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [BLOCK_W-1:0] block_t;
    typedef logic [SEL_W-1:0]   sel_t;

    typedef enum logic {IDLE, SEND} ser_state_t;

endpackage

// File: rtl/aes_word_serializer_if.sv
// rtl/aes_word_serializer_if.sv - block-in / word-out handshake bundle of the serializer
interface aes_word_serializer_if #(
    parameter int WORD_W = aes_pkg::WORD_W,
    parameter int NWORDS = aes_pkg::NWORDS
);
    localparam int SEL_W = $clog2(NWORDS);

    logic                       in_valid;
    logic                       in_ready;
    logic [WORD_W*NWORDS-1:0]   in_block;
    logic                       out_valid;
    logic                       out_ready;
    logic [WORD_W-1:0]          out_word;
    logic [SEL_W-1:0]           out_sel;
    logic                       out_last;
    logic                       busy;

    modport master (
        output in_valid, in_block, out_ready,
        input  in_ready, out_valid, out_word, out_sel, out_last, busy
    );

    modport slave (
        input  in_valid, in_block, out_ready,
        output in_ready, out_valid, out_word, out_sel, out_last, busy
    );

endinterface

// File: rtl/aes_word_serializer.sv
// rtl/aes_word_serializer.sv - splits a 128-bit AES block into four indexed 32-bit words
module aes_word_serializer #(
    parameter int WORD_W = aes_pkg::WORD_W,
    parameter int NWORDS = aes_pkg::NWORDS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aes_word_serializer_if.slave  bus
);
    import aes_pkg::*;

    localparam int             BLK_W = WORD_W * NWORDS;
    localparam int             CNT_W = $clog2(NWORDS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NWORDS - 1);

    logic [1:0]       rst_sync_q;
    logic             rst_int_n;
    ser_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BLK_W-1:0] buf_q, buf_d;
    logic             out_valid, out_hs, at_last, in_ready, accept;
    logic [WORD_W-1:0] word_mux;

    // Reset asserts immediately but releases only after two clean clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        out_valid = (state_q == SEND);
        out_hs    = out_valid && bus.out_ready;
        at_last   = (cnt_q == LAST);
        // The last word leaving frees the buffer in the same cycle, so a waiting block loads with no bubble.
        in_ready  = (state_q == IDLE) || (out_hs && at_last);
        accept    = bus.in_valid && in_ready;

        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        if (accept) begin
            buf_d   = bus.in_block;
            cnt_d   = '0;
            state_d = SEND;
        end else if (out_hs) begin
            if (at_last) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        word_mux = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                word_mux = buf_q[(NWORDS-1-i)*WORD_W +: WORD_W];
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_word  = word_mux;
    assign bus.out_sel   = cnt_q;
    assign bus.out_last  = out_valid && at_last;
    assign bus.busy      = out_valid;

endmodule

// File: tb/tb_aes_word_serializer.sv
// tb/tb_aes_word_serializer.sv - directed and randomized checks of aes_word_serializer against a word-queue model
module tb_aes_word_serializer;
    import aes_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    aes_word_serializer_if bus ();

    aes_word_serializer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a block is four pending words; the head of the queue is what the bus must show.
    word_t  word_q[$];
    sel_t   sel_q[$];
    block_t blk_q[$];
    word_t  ld[4];
    logic   exp_valid;
    logic   exp_ready;

    localparam block_t B1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam block_t B2 = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
    word_t  w1[4];
    word_t  w2[4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        word_q.delete();
        sel_q.delete();
        blk_q.delete();
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            model_clear();
        end else begin
            exp_valid = (word_q.size() != 0);
            exp_ready = (word_q.size() == 0) || (word_q.size() == 1 && bus.out_ready);
            chk("m_out_valid", bus.out_valid, exp_valid);
            chk("m_busy", bus.busy, exp_valid);
            chk("m_in_ready", bus.in_ready, exp_ready);
            if (exp_valid) begin
                chk("m_out_word", bus.out_word, word_q[0]);
                chk("m_out_sel", bus.out_sel, sel_q[0]);
                chk("m_out_last", bus.out_last, sel_q[0] == 2'd3);
            end else begin
                chk("m_out_last_idle", bus.out_last, 1'b0);
            end
            if (exp_valid && bus.out_ready) begin
                ld[bus.out_sel] = bus.out_word;
                if (sel_q[0] == 2'd3) begin
                    chk("loopback", {ld[0], ld[1], ld[2], ld[3]}, blk_q.pop_front());
                end
                void'(word_q.pop_front());
                void'(sel_q.pop_front());
            end
            if (bus.in_valid && exp_ready) begin
                blk_q.push_back(bus.in_block);
                for (int i = 0; i < 4; i++) begin
                    word_q.push_back(bus.in_block[127-32*i -: 32]);
                    sel_q.push_back(sel_t'(i));
                end
            end
        end
    end

    initial begin
        int  sent;
        int  cyc;
        logic acc;
        int  idx2[7];

        total = 0;
        bad   = 0;
        w1 = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
        w2 = '{32'hFFEEDDCC, 32'hBBAA9988, 32'h77665544, 32'h33221100};
        idx2 = '{0, 1, 1, 1, 1, 2, 3};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_block  = '0;
        bus.out_ready = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_word", bus.out_word, 32'h0);
        chk("rst_out_sel", bus.out_sel, 2'd0);
        chk("rst_out_last", bus.out_last, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (4) step();

        // Single block, consumer always ready.
        bus.in_valid = 1'b1; bus.in_block = B1; bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t1_in_ready", bus.in_ready, 1'b1);
        step();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t1_sel", bus.out_sel, k[1:0]);
            chk("t1_word", bus.out_word, w1[k]);
            chk("t1_last", bus.out_last, k == 3);
            step();
        end
        @(negedge clk);
        chk("t1_busy_drop", bus.busy, 1'b0);
        step();

        // Three-cycle stall on word 1.
        bus.in_valid = 1'b1; bus.in_block = B1; bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            bus.out_ready = (c >= 1 && c <= 3) ? 1'b0 : 1'b1;
            @(negedge clk);
            chk("t2_word", bus.out_word, w1[idx2[c]]);
            chk("t2_valid", bus.out_valid, 1'b1);
            step();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t2_done_7", bus.out_valid, 1'b0);
        step();

        // Back-to-back blocks with in_valid held.
        bus.in_valid = 1'b1; bus.in_block = B1;
        step();
        bus.in_block = B2;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("t3_word", bus.out_word, (c < 4) ? w1[c] : w2[c-4]);
            chk("t3_sel", bus.out_sel, c[1:0]);
            if (c == 3) chk("t3_in_ready_sel3", bus.in_ready, 1'b1);
            if (c == 2) chk("t3_in_ready_sel2", bus.in_ready, 1'b0);
            step();
            if (c == 3) bus.in_valid = 1'b0;
        end
        @(negedge clk);
        chk("t3_idle", bus.out_valid, 1'b0);
        step();

        // A block offered mid-send is ignored.
        bus.in_valid = 1'b1; bus.in_block = B1;
        step();
        bus.in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin bus.in_valid = 1'b1; bus.in_block = B2; end
            @(negedge clk);
            chk("t4_word", bus.out_word, w1[c]);
            if (c == 1) chk("t4_in_ready", bus.in_ready, 1'b0);
            step();
            bus.in_valid = 1'b0;
        end
        @(negedge clk);
        chk("t4_idle", bus.out_valid, 1'b0);
        step();

        // Reset while word 2 is on the bus.
        bus.in_valid = 1'b1; bus.in_block = B1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        chk("t5_sel_before", bus.out_sel, 2'd2);
        rst_n = 1'b0;
        #1;
        chk("t5_valid_async", bus.out_valid, 1'b0);
        chk("t5_busy_async", bus.busy, 1'b0);
        chk("t5_in_ready", bus.in_ready, 1'b1);
        repeat (2) step();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t5_no_stale", bus.out_valid, 1'b0);
            chk("t5_ready_after", bus.in_ready, 1'b1);
            step();
        end

        // Randomized traffic with random backpressure.
        sent = 0;
        cyc  = 0;
        while ((sent < 100 || word_q.size() != 0) && cyc < 20000) begin
            if (!bus.in_valid && sent < 100 && $urandom_range(2) != 0) begin
                bus.in_block = {$urandom(), $urandom(), $urandom(), $urandom()};
                bus.in_valid = 1'b1;
            end
            bus.out_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            step();
            cyc++;
            if (acc) begin
                bus.in_valid = 1'b0;
                sent++;
            end
        end
        chk("t6_all_sent", sent, 100);
        chk("t6_drained", word_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
